// File: rtl/dot_product_sequencer.sv
// Sequences a shared 1-cycle-latency ALU through MUL/ADD pairs to form one
// dot product sum(A[k]*B[k]) from two synchronous-read operand memories.
module dot_product_sequencer #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] len,
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] b_base,
  input  logic [AW-1:0] b_stride,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  input  logic [DW-1:0] a_data,
  input  logic [DW-1:0] b_data,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [2:0]    alu_control,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_zflag,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          result_zero
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MULT,
    ACC,
    WB,
    DONE
  } state_e;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;

  state_e        state_q, state_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] stride_q, stride_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [AW-1:0] a_addr_q, a_addr_d;
  logic [AW-1:0] b_addr_q, b_addr_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] result_q, result_d;
  logic          rzero_q, rzero_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      stride_q <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      ctrl_q   <= OP_NOP;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rzero_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      stride_q <= stride_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      ctrl_q   <= ctrl_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      rzero_q  <= rzero_d;
    end
  end

  // Registered outputs are loaded on the edge entering the state they belong to;
  // the B pointer advances by the stride instead of multiplying idx*stride.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    stride_d = stride_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    rzero_d  = rzero_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = len;
          stride_d = b_stride;
          idx_d    = '0;
          acc_d    = '0;
          a_addr_d = a_base;
          b_addr_d = b_base;
          busy_d   = 1'b1;
          result_d = '0;
          rzero_d  = 1'b0;
          if (len != '0) begin
            state_d = FETCH;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            rzero_d = 1'b1;
          end
        end
      end
      FETCH: state_d = MULT;
      MULT:  state_d = ACC;
      ACC:   state_d = WB;
      WB: begin
        acc_d = alu_out;
        idx_d = idx_q + AW'(1);
        if (idx_q == len_q - AW'(1)) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = alu_out;
          rzero_d  = alu_zflag;
        end else begin
          state_d  = FETCH;
          a_addr_d = a_addr_q + AW'(1);
          b_addr_d = b_addr_q + stride_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl_d = OP_NOP;
    case (state_d)
      MULT:    ctrl_d = OP_MUL;
      ACC:     ctrl_d = OP_ADD;
      default: ctrl_d = OP_NOP;
    endcase
  end

  // Operands are steered straight from the memory and ALU result ports so a MUL
  // and its dependent ADD can run in back-to-back cycles on a 1-cycle ALU.
  always_comb begin
    alu_in1 = '0;
    alu_in2 = '0;
    case (state_q)
      MULT: begin
        alu_in1 = a_data;
        alu_in2 = b_data;
      end
      ACC: begin
        alu_in1 = alu_out;
        alu_in2 = acc_q;
      end
      default: begin
        alu_in1 = '0;
        alu_in2 = '0;
      end
    endcase
  end

  assign a_addr      = a_addr_q;
  assign b_addr      = b_addr_q;
  assign alu_control = ctrl_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign result_zero = rzero_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: operand memories and a registered ALU around
// the DUT, a cycle-level expectation model, and directed dot-product jobs.
module tb_dot_product_sequencer;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] len = '0;
  logic [AW-1:0] aBase = '0;
  logic [AW-1:0] bBase = '0;
  logic [AW-1:0] bStride = '0;
  logic [AW-1:0] aAddr, bAddr;
  logic [DW-1:0] aData = '0;
  logic [DW-1:0] bData = '0;
  logic [DW-1:0] aluIn1, aluIn2;
  logic [DW-1:0] aluOut = '0;
  logic [2:0]    aluControl;
  logic          aluZflag;
  logic          busy, done;
  logic [DW-1:0] result;
  logic          resultZero;

  logic [DW-1:0] memA [DEPTH];
  logic [DW-1:0] memB [DEPTH];

  logic [AW-1:0] expAddrA [DEPTH];
  logic [AW-1:0] expAddrB [DEPTH];
  logic [DW-1:0] expOpA   [DEPTH];
  logic [DW-1:0] expOpB   [DEPTH];
  logic [DW-1:0] expProd  [DEPTH];
  logic [DW-1:0] expPart  [DEPTH];
  logic [DW-1:0] jobSum = '0;
  logic [AW-1:0] aLog [$];
  logic [AW-1:0] bLog [$];

  logic          mIdle = 1'b1;
  int            mT = 0;
  int            mLen = 0;
  logic [DW-1:0] mResult = '0;
  logic          mZero = 1'b1;
  int            cmpK, cmpPh;

  int checks = 0;
  int errors = 0;

  dot_product_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .a_base(aBase), .b_base(bBase), .b_stride(bStride),
    .a_addr(aAddr), .b_addr(bAddr), .a_data(aData), .b_data(bData),
    .alu_in1(aluIn1), .alu_in2(aluIn2), .alu_control(aluControl),
    .alu_out(aluOut), .alu_zflag(aluZflag),
    .busy(busy), .done(done), .result(result), .result_zero(resultZero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    aData <= memA[aAddr];
    bData <= memB[bAddr];
  end

  always @(posedge clk) begin
    case (aluControl)
      3'b001:  aluOut <= aluIn1 * aluIn2;
      3'b010:  aluOut <= aluIn1 + aluIn2;
      default: aluOut <= aluOut;
    endcase
  end
  assign aluZflag = (aluOut == '0);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Job timing: cycle t after the accept edge; element k occupies t=4k+1..4k+4, done at 4*len+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mIdle   <= 1'b1;
      mT      <= 0;
      mResult <= '0;
      mZero   <= 1'b1;
    end else if (mIdle) begin
      if (start) begin
        mIdle <= 1'b0;
        mT    <= 1;
        mLen  <= int'(len);
        if (len == '0) begin
          mResult <= jobSum;
          mZero   <= (jobSum == '0);
        end else begin
          mResult <= '0;
          mZero   <= 1'b0;
        end
      end
    end else if (mT == 4 * mLen + 1) begin
      mIdle <= 1'b1;
    end else begin
      mT <= mT + 1;
      if (mT + 1 == 4 * mLen + 1) begin
        mResult <= jobSum;
        mZero   <= (jobSum == '0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst a_addr", aAddr, 0);
      checkOutput("rst b_addr", bAddr, 0);
      checkOutput("rst alu_in1", aluIn1, 0);
      checkOutput("rst alu_in2", aluIn2, 0);
      checkOutput("rst alu_control", aluControl, 0);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst done", done, 0);
      checkOutput("rst result", result, 0);
      checkOutput("rst result_zero", resultZero, 1);
    end else if (mIdle) begin
      checkOutput("idle busy", busy, 0);
      checkOutput("idle done", done, 0);
      checkOutput("idle alu_control", aluControl, 0);
      checkOutput("idle result", result, mResult);
      checkOutput("idle result_zero", resultZero, mZero);
    end else begin
      cmpK  = (mT - 1) / 4;
      cmpPh = (mT - 1) % 4;
      checkOutput("busy", busy, 1);
      checkOutput("done", done, (mT == 4 * mLen + 1) ? 1 : 0);
      checkOutput("result", result, mResult);
      checkOutput("result_zero", resultZero, mZero);
      if (mT == 4 * mLen + 1) begin
        checkOutput("done alu_control", aluControl, 0);
      end else begin
        checkOutput("alu_control", aluControl, (cmpPh == 1) ? 1 : (cmpPh == 2) ? 2 : 0);
        if (cmpPh == 0) begin
          checkOutput("a_addr", aAddr, expAddrA[cmpK]);
          checkOutput("b_addr", bAddr, expAddrB[cmpK]);
          aLog.push_back(aAddr);
          bLog.push_back(bAddr);
        end else if (cmpPh == 1) begin
          checkOutput("mul in1", aluIn1, expOpA[cmpK]);
          checkOutput("mul in2", aluIn2, expOpB[cmpK]);
        end else if (cmpPh == 2) begin
          checkOutput("add in1", aluIn1, expProd[cmpK]);
          checkOutput("add in2", aluIn2, expPart[cmpK]);
        end
      end
    end
  end

  task automatic prepJob(input int l, input int ab, input int bb, input int st);
    logic [DW-1:0] runSum;
    logic [DW-1:0] p;
    int ai, bi;
    runSum = '0;
    for (int k = 0; k < l; k++) begin
      ai = (ab + k) % DEPTH;
      bi = (bb + k * st) % DEPTH;
      expAddrA[k] = AW'(ai);
      expAddrB[k] = AW'(bi);
      expOpA[k]   = memA[ai];
      expOpB[k]   = memB[bi];
      p           = memA[ai] * memB[bi];
      expProd[k]  = p;
      expPart[k]  = runSum;
      runSum      = runSum + p;
    end
    jobSum = runSum;
    aLog.delete();
    bLog.delete();
  endtask

  task automatic applyStimulus(input int l, input int ab, input int bb, input int st,
                               input bit noise, output int doneCyc);
    prepJob(l, ab, bb, st);
    @(negedge clk);
    len     = AW'(l);
    aBase   = AW'(ab);
    bBase   = AW'(bb);
    bStride = AW'(st);
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    doneCyc = -1;
    for (int c = 1; c <= 4 * l + 20; c++) begin
      @(negedge clk);
      if (noise && c >= 2 && c <= 5) begin
        start   = 1'b1;
        len     = 8'd1;
        aBase   = 8'd9;
        bBase   = 8'd9;
        bStride = 8'd2;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        doneCyc = c;
        break;
      end
    end
    start = 1'b0;
    checkOutput("done latency", doneCyc, 4 * l + 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int dc;
    int doneSeen;
    for (int i = 0; i < DEPTH; i++) begin
      memA[i] = '0;
      memB[i] = '0;
    end
    @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset result_zero", resultZero, 1);
    @(negedge clk);
    #1 rst_n = 1'b1;

    memA[0] = 16'd1; memA[1] = 16'd2; memA[2] = 16'd3;
    memB[0] = 16'd4; memB[1] = 16'd5; memB[2] = 16'd6;
    applyStimulus(3, 0, 0, 1, 1'b0, dc);
    checkOutput("t1 done cycle", dc, 13);
    checkOutput("t1 result", result, 32);
    checkOutput("t1 result_zero", resultZero, 0);
    checkOutput("t1 a_addr count", aLog.size(), 3);
    checkOutput("t1 a_addr[0]", aLog[0], 0);
    checkOutput("t1 a_addr[1]", aLog[1], 1);
    checkOutput("t1 a_addr[2]", aLog[2], 2);

    memA[0] = 16'd2; memA[1] = 16'd3;
    memB[1] = 16'd7; memB[5] = 16'd9;
    applyStimulus(2, 0, 1, 4, 1'b0, dc);
    checkOutput("t2 result", result, 41);
    checkOutput("t2 b_addr count", bLog.size(), 2);
    checkOutput("t2 b_addr[0]", bLog[0], 1);
    checkOutput("t2 b_addr[1]", bLog[1], 5);

    applyStimulus(0, 0, 0, 1, 1'b0, dc);
    checkOutput("t3 done cycle", dc, 1);
    checkOutput("t3 result", result, 0);
    checkOutput("t3 result_zero", resultZero, 1);

    memA[0] = 16'd300; memA[1] = 16'd1;
    memB[0] = 16'd300; memB[1] = 16'd0;
    applyStimulus(2, 0, 0, 1, 1'b0, dc);
    checkOutput("t4 wrap result", result, 24464);
    checkOutput("t4 wrap result_zero", resultZero, 0);
    memA[0] = 16'd0; memA[1] = 16'd0;
    applyStimulus(2, 0, 0, 1, 1'b0, dc);
    checkOutput("t4 zero result", result, 0);
    checkOutput("t4 zero result_zero", resultZero, 1);

    memA[0] = 16'd1; memA[1] = 16'd2; memA[2] = 16'd3;
    memB[0] = 16'd4; memB[1] = 16'd5; memB[2] = 16'd6;
    applyStimulus(3, 0, 0, 1, 1'b1, dc);
    checkOutput("t5 busy-start result", result, 32);
    applyStimulus(1, 0, 0, 1, 1'b0, dc);
    checkOutput("t5 next done cycle", dc, 5);
    checkOutput("t5 next result", result, 4);

    memA[254] = 16'd5; memA[255] = 16'd6; memA[0] = 16'd7;
    memB[250] = 16'd2; memB[255] = 16'd3; memB[4] = 16'd4;
    applyStimulus(3, 254, 250, 5, 1'b0, dc);
    checkOutput("addr wrap result", result, 56);
    checkOutput("addr wrap a_addr[2]", aLog[2], 0);
    checkOutput("addr wrap b_addr[2]", bLog[2], 4);

    memA[0] = 16'd1;
    prepJob(3, 0, 0, 1);
    @(negedge clk);
    len = 8'd3; aBase = 8'd0; bBase = 8'd0; bStride = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("t6 in MULT", aluControl, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6 rst busy", busy, 0);
    checkOutput("t6 rst alu_control", aluControl, 0);
    checkOutput("t6 rst a_addr", aAddr, 0);
    checkOutput("t6 rst result_zero", resultZero, 1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    doneSeen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    checkOutput("t6 no done", doneSeen, 0);
    applyStimulus(3, 0, 0, 1, 1'b0, dc);
    checkOutput("t6 rerun result", result, 32);
    checkOutput("t6 rerun a_addr[0]", aLog[0], 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
